// File: rtl/seq_divider_pkg.sv
// Shared arithmetic definitions for the sequential divider.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Counter width able to hold the value WIDTH.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEFAULT_COUNT_W = count_width(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and try
// to subtract the divisor from the partial remainder.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  // The extra top bit of the trial acts as its sign.  The partial remainder is
  // always below the divisor, so the shifted value never loses information.
  logic [WIDTH+1:0] trial;

  // Trial subtraction and restore decision.
  always_comb begin
    trial = {rem, q_msb} - {2'b00, divisor};
    if (trial[WIDTH+1]) begin
      rem_next = {rem[WIDTH-1:0], q_msb};
      q_bit    = 1'b0;
    end else begin
      rem_next = trial[WIDTH:0];
      q_bit    = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: restoring shift-and-subtract, one quotient bit
// per clock, truncating toward zero, with a divide-by-zero flag.
import seq_divider_pkg::*;

module seq_divider #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CNT_W = count_width(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic             sign_dd;
  logic             sign_dr;
  logic             div0;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   step_rem;
  logic             step_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .q_msb    (q_reg[WIDTH-1]),
    .divisor  (dvsr),
    .rem_next (step_rem),
    .q_bit    (step_qbit)
  );

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      count         <= '0;
      sign_dd       <= 1'b0;
      sign_dr       <= 1'b0;
      div0          <= 1'b0;
      q_reg         <= '0;
      dvsr          <= '0;
      rem           <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            sign_dd       <= i_dividend[WIDTH-1];
            sign_dr       <= i_divisor[WIDTH-1];
            q_reg         <= i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
            dvsr          <= i_divisor[WIDTH-1] ? -i_divisor : i_divisor;
            rem           <= '0;
            count         <= '0;
            div0          <= (i_divisor == '0);
            o_busy        <= 1'b1;
            o_div_by_zero <= 1'b0;
            state         <= (i_divisor == '0) ? ST_FIX : ST_CALC;
          end
        end
        ST_CALC: begin
          rem   <= step_rem;
          q_reg <= {q_reg[WIDTH-2:0], step_qbit};
          count <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          // On divide-by-zero q_reg still holds |dividend|; re-applying the
          // dividend sign recovers the original operand for the remainder.
          if (div0) begin
            o_quotient  <= '1;
            o_remainder <= sign_dd ? -q_reg : q_reg;
          end else begin
            o_quotient  <= (sign_dd ^ sign_dr) ? -q_reg : q_reg;
            o_remainder <= sign_dd ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          end
          o_div_by_zero <= div0;
          o_done        <= 1'b1;
          o_busy        <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH = 32).
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        dbz;

  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct {
    logic [31:0] dd;
    logic [31:0] dr;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int unsigned lat;
  } vec_t;

  vec_t vecs[12];

  seq_divider #(.WIDTH(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request at the next negedge; returns after the accept edge (+1).
  task automatic issue(input logic [31:0] dd, input logic [31:0] dr);
    @(negedge clk);
    start    = 1'b1;
    dividend = dd;
    divisor  = dr;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for o_done; returns the number of edges after accept.
  task automatic wait_done(output int unsigned cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int unsigned cycles);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " latency"}, cycles, v.lat);
    check({tag, " quotient"}, quotient, v.q);
    check({tag, " remainder"}, remainder, v.r);
    check({tag, " div_by_zero"}, {31'd0, dbz}, {31'd0, v.z});
    check({tag, " busy_clear"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned done_seen;
    vec_t v;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    //        dividend      divisor       quotient      remainder     dbz  latency
    vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33};
    vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33};
    vecs[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 33};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33};
    vecs[4]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 33};
    vecs[5]  = '{32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234,     1'b1, 1};
    vecs[6]  = '{32'hFFFFFB2E, 32'd0,        32'hFFFFFFFF, 32'hFFFFFB2E, 1'b1, 1};
    vecs[7]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
    vecs[8]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
    vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 33};
    vecs[10] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0, 33};
    vecs[11] = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 33};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      issue(v.dd, v.dr);
      check($sformatf("vec%0d busy_at_accept", i), {31'd0, busy}, 32'd1);
      if (v.z == 1'b0) begin
        check($sformatf("vec%0d dbz_cleared_at_accept", i), {31'd0, dbz}, 32'd0);
      end
      wait_done(cyc);
      check_result($sformatf("vec%0d", i), v, cyc);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d done_one_cycle", i), {31'd0, done}, 32'd0);
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd55;
    divisor  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_start outputs_held_q", quotient, 32'd0);
    check("busy_start outputs_held_r", remainder, 32'd0);
    wait_done(cyc);
    v = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 27};
    check_result("busy_start first", v, cyc);
    start    = 1'b1;
    dividend = 32'd55;
    divisor  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b accepted busy", {31'd0, busy}, 32'd1);
    check("b2b done_cleared", {31'd0, done}, 32'd0);
    wait_done(cyc);
    v = '{32'd55, 32'd5, 32'd11, 32'd0, 1'b0, 33};
    check_result("b2b second", v, cyc);

    // Reset in the middle of CALC aborts without a done pulse.
    issue(32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst quotient", quotient, 32'd0);
    check("midrst remainder", remainder, 32'd0);
    check("midrst dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    check("midrst no_done", done_seen, 32'd0);
    issue(32'd12, 32'd13);
    wait_done(cyc);
    v = '{32'd12, 32'd13, 32'd0, 32'd12, 1'b0, 33};
    check_result("after_rst", v, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
